sync_fifo_flags: RTL and testbench

//   Parametrised single-clock FIFO: next generation of the team's 8x8 FIFO.

---
 rtl/sync_fifo_flags.sv | 89 ++++++++
 tb/tb_sync_fifo_flags.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty
// flags, overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           datain,
    output logic [WIDTH-1:0]           out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             pop_ok;
    logic             push_ok;

    // Non-power-of-2 depths need an explicit wrap instead of natural overflow.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_TH));
    assign almost_empty = (count <= CW'(AEMPTY_TH));

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // NOTE: non-blocking assignments everywhere in clocked blocks so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push & ~push_ok;
            underflow <= pop & empty;
            if (push_ok) wptr <= ptr_inc(wptr);
            if (pop_ok)  rptr <= ptr_inc(rptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable through
    // count/rptr, which are reset, so resetting it would just cost flops.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= datain;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out = empty ? '0 : mem[rptr];
        end else begin : g_reg
            logic [WIDTH-1:0] out_q;
            // At full with push+pop this reads the old head, since mem updates at the same edge.
            always_ff @(posedge clk) begin
                if (rst)         out_q <= '0;
                else if (pop_ok) out_q <= mem[rptr];
            end
            assign out = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: three FIFO configurations driven in lockstep, a directed vector
// table, hand-written corner sequences and random traffic against a queue-level model.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] din = 8'h00;

    always #5 clk = ~clk;

    // Instance a: 8x8 registered read. b: depth 5. c: 8x8 first-word-fall-through.
    logic [7:0] out_a, out_b, out_c;
    logic [3:0] cnt_a, cnt_c;
    logic [2:0] cnt_b;
    logic [5:0] fl_a, fl_b, fl_c;   // {full, empty, almost_full, almost_empty, overflow, underflow}

    sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u_dut_a (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .datain(din), .out(out_a),
        .full(fl_a[5]), .empty(fl_a[4]), .almost_full(fl_a[3]), .almost_empty(fl_a[2]),
        .count(cnt_a), .overflow(fl_a[1]), .underflow(fl_a[0]));

    sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(0)) u_dut_b (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .datain(din), .out(out_b),
        .full(fl_b[5]), .empty(fl_b[4]), .almost_full(fl_b[3]), .almost_empty(fl_b[2]),
        .count(cnt_b), .overflow(fl_b[1]), .underflow(fl_b[0]));

    sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) u_dut_c (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .datain(din), .out(out_c),
        .full(fl_c[5]), .empty(fl_c[4]), .almost_full(fl_c[3]), .almost_empty(fl_c[2]),
        .count(cnt_c), .overflow(fl_c[1]), .underflow(fl_c[0]));

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): actual=%0h expected=%0h", name, ncyc, act, exp);
        end
    endtask

    // Reference model: each FIFO is an ordered list whose head is element 0.
    logic [7:0] mbuf [3][8];
    int         msz  [3];
    logic [7:0] mout [3];
    logic       movf [3];
    logic       mudf [3];

    function automatic int dep(input int m);   return (m == 1) ? 5 : 8; endfunction
    function automatic int af_th(input int m); return (m == 1) ? 4 : 6; endfunction
    function automatic int ae_th(input int m); return (m == 1) ? 1 : 2; endfunction

    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            logic pop_ok;
            logic push_ok;
            if (rst) begin
                msz[m] = 0; mout[m] = 8'h00; movf[m] = 1'b0; mudf[m] = 1'b0;
            end else begin
                pop_ok  = pop && (msz[m] > 0);
                push_ok = push && ((msz[m] < dep(m)) || pop_ok);
                movf[m] = push && !push_ok;
                mudf[m] = pop && (msz[m] == 0);
                if (pop_ok) begin
                    if (m != 2) mout[m] = mbuf[m][0];
                    for (int i = 0; i < 7; i++) mbuf[m][i] = mbuf[m][i+1];
                    msz[m]--;
                end
                if (push_ok) begin
                    mbuf[m][msz[m]] = din;
                    msz[m]++;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_out(input int m);
        if (m == 2) return (msz[m] == 0) ? 8'h00 : mbuf[m][0];
        return mout[m];
    endfunction

    function automatic logic [9:0] exp_st(input int m);
        return {4'(msz[m]), msz[m] == dep(m), msz[m] == 0, msz[m] >= af_th(m),
                msz[m] <= ae_th(m), movf[m], mudf[m]};
    endfunction

    function automatic logic [9:0] dut_st(input int m);
        case (m)
            0:       return {cnt_a, fl_a};
            1:       return {1'b0, cnt_b, fl_b};
            default: return {cnt_c, fl_c};
        endcase
    endfunction

    function automatic logic [7:0] dut_out(input int m);
        case (m)
            0:       return out_a;
            1:       return out_b;
            default: return out_c;
        endcase
    endfunction

    // Drive one cycle (inputs change on the falling edge), then compare all instances.
    task automatic cycle(input logic r, input logic pu, input logic po, input logic [7:0] d);
        rst = r; push = pu; pop = po; din = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        ncyc++;
        for (int m = 0; m < 3; m++) begin
            check($sformatf("model out[%0d]", m), 32'(dut_out(m)), 32'(exp_out(m)));
            check($sformatf("model status[%0d]", m), 32'(dut_st(m)), 32'(exp_st(m)));
        end
    endtask

    typedef struct {
        logic       r;
        logic       pu;
        logic       po;
        logic [7:0] d;
        logic [7:0] eout;
        int         ecnt;
        logic       eovf;
        logic       eudf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic pu, input logic po, input logic [7:0] d,
                       input logic [7:0] eout, input int ecnt, input logic eovf, input logic eudf);
        vec_t v;
        v.r = r; v.pu = pu; v.po = po; v.d = d;
        v.eout = eout; v.ecnt = ecnt; v.eovf = eovf; v.eudf = eudf;
        tbl.push_back(v);
    endtask

    // Expected status of instance a from its count and pulse bits.
    function automatic logic [9:0] st_a(input int c, input logic o, input logic u);
        return {4'(c), c == 8, c == 0, c >= 6, c <= 2, o, u};
    endfunction

    initial begin
        // Fill, overflow, in-order drain and underflow.
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'(i), 8'h00, i, 0, 0);
        add(0, 1, 0, 8'hFF, 8'h00, 8, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 8, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 0, 1, 8'h00, 8'(i), 8 - i, 0, 0);
        add(0, 0, 1, 8'h00, 8'h08, 0, 0, 1);
        add(0, 0, 0, 8'h00, 8'h08, 0, 0, 0);
        // Push+pop at full, then drain to the word written during that cycle.
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'(i), 8'h08, i, 0, 0);
        add(0, 1, 1, 8'h55, 8'h01, 8, 0, 0);
        for (int i = 2; i <= 8; i++) add(0, 0, 1, 8'h00, 8'(i), 9 - i, 0, 0);
        add(0, 0, 1, 8'h00, 8'h55, 0, 0, 0);
        // Push+pop at empty: only the push lands.
        add(0, 1, 1, 8'hA5, 8'h55, 1, 0, 1);
        add(0, 0, 1, 8'h00, 8'hA5, 0, 0, 0);
        // Reset with entries present overrides a concurrent push.
        for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h70 + 8'(i), 8'hA5, i + 1, 0, 0);
        add(1, 1, 0, 8'h99, 8'h00, 0, 0, 0);

        foreach (tbl[k]) begin
            cycle(tbl[k].r, tbl[k].pu, tbl[k].po, tbl[k].d);
            check($sformatf("tbl[%0d] out", k), 32'(out_a), 32'(tbl[k].eout));
            check($sformatf("tbl[%0d] status", k), 32'({cnt_a, fl_a}),
                  32'(st_a(tbl[k].ecnt, tbl[k].eovf, tbl[k].eudf)));
        end

        // Depth 5: seven pushes give five accepted words and two overflow pulses.
        cycle(1, 0, 0, 8'h00);
        for (int i = 1; i <= 7; i++) begin
            cycle(0, 1, 0, 8'h10 + 8'(i));
            check($sformatf("d5 push%0d count", i), 32'(cnt_b), (i > 5) ? 32'd5 : 32'(i));
            check($sformatf("d5 push%0d overflow", i), 32'(fl_b[1]), (i > 5) ? 32'd1 : 32'd0);
        end
        cycle(0, 0, 0, 8'h00);
        check("d5 overflow clears", 32'(fl_b[1]), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 0, 1, 8'h00);
            check($sformatf("d5 pop%0d out", i), 32'(out_b), 32'h10 + 32'(i));
        end
        check("d5 empty after drain", 32'(fl_b[4]), 32'd1);

        // FWFT: head visible without a pop; reset clears the combinational output.
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 0, 8'h3C);
        check("fwft head shows", 32'(out_c), 32'h3C);
        cycle(0, 1, 0, 8'h3D);
        cycle(0, 1, 0, 8'h3E);
        check("fwft head holds", 32'(out_c), 32'h3C);
        cycle(1, 1, 0, 8'h3F);
        check("fwft rst count", 32'(cnt_c), 32'd0);
        check("fwft rst empty", 32'(fl_c[4]), 32'd1);
        check("fwft rst out", 32'(out_c), 32'h00);

        // Random traffic with alternating fill/drain bias to exercise wrap and both limits.
        for (int blk = 0; blk < 8; blk++) begin
            int bias;
            bias = (blk % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 80; i++) begin
                cycle($urandom_range(63) == 0,
                      $urandom_range(99) < bias,
                      $urandom_range(99) >= bias,
                      8'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
